// File: rtl/rv32i_dmem_arbiter.sv
// rv32i_dmem_arbiter: shares the data port of a synchronous RAM between the
// core load/store unit (requester 0) and the debug/test loader (requester 1).
// Each access is accepted, issued to the RAM once, and answered with a
// one-cycle response that carries extended load data or an error flag.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// always wins); otherwise the two requesters are served round-robin.
module rv32i_dmem_arbiter #(
   parameter int NREQ = 2,
   parameter int XLEN = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ*XLEN-1:0]   req_addr,
   input  logic [NREQ*XLEN-1:0]   req_wdata,
   input  logic [2*NREQ-1:0]      req_width,
   input  logic [NREQ-1:0]        req_sign,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [XLEN-1:0]        rsp_rdata,
   output logic                   rsp_err,
   output logic [XLEN-1:0]        ram_addr,
   output logic                   ram_we,
   output logic [3:0]             ram_be,
   output logic [XLEN-1:0]        ram_wdata,
   input  logic [XLEN-1:0]        ram_rdata
);

   // state | meaning
   // IDLE  | waiting for a request; req_ready strobes the accepted requester
   // ISSUE | access presented to the RAM (address, byte enables, write data)
   // RESP  | one-cycle response pulse to the owner with load data or error
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              owner_q;
   logic              we_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [1:0]        width_q;
   logic              sign_q;
   logic              err_q;
   logic [XLEN-1:0]   ram_addr_q;
   // Blocks acceptance in the cycle right after reset so every output is 0 then.
   logic              out_en_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
   logic              rr_last_q;
`endif

   logic              winner;
   logic              accept;
   logic              in_we;
   logic [XLEN-1:0]   in_addr;
   logic [XLEN-1:0]   in_wdata;
   logic [1:0]        in_width;
   logic              in_sign;
   logic              in_bad;
   logic [XLEN-1:0]   rd_shift;
   logic [XLEN-1:0]   rd_ext;

   // Winner selection, field mux for the winner, and alignment check.
   always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      winner = !req_valid[0];
`else
      winner = req_valid[1] && (!req_valid[0] || !rr_last_q);
`endif
      accept   = reset_n && out_en_q && (state_q == IDLE) && (|req_valid);
      in_we    = winner ? req_we[1]                : req_we[0];
      in_addr  = winner ? req_addr[2*XLEN-1:XLEN]  : req_addr[XLEN-1:0];
      in_wdata = winner ? req_wdata[2*XLEN-1:XLEN] : req_wdata[XLEN-1:0];
      in_width = winner ? req_width[3:2]           : req_width[1:0];
      in_sign  = winner ? req_sign[1]              : req_sign[0];
      case (in_width)
         2'b00:   in_bad = 1'b0;
         2'b01:   in_bad = in_addr[0];
         2'b10:   in_bad = |in_addr[1:0];
         default: in_bad = 1'b1;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = in_bad ? RESP : ISSUE;
         ISSUE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register and access capture on accept.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         width_q    <= 2'b00;
         sign_q     <= 1'b0;
         err_q      <= 1'b0;
         ram_addr_q <= '0;
         out_en_q   <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         rr_last_q  <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         out_en_q <= 1'b1;
         if (accept) begin
            owner_q   <= winner;
            we_q      <= in_we;
            addr_q    <= in_addr;
            wdata_q   <= in_wdata;
            width_q   <= in_width;
            sign_q    <= in_sign;
            err_q     <= in_bad;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            rr_last_q <= winner;
`endif
         end
         if (state_q == ISSUE) ram_addr_q <= {addr_q[XLEN-1:2], 2'b00};
      end
   end

   // Load lane extraction and sign/zero extension.
   always_comb begin
      rd_shift = ram_rdata >> {addr_q[1:0], 3'b000};
      case (width_q)
         2'b00:   rd_ext = sign_q ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                  : {24'h000000, rd_shift[7:0]};
         2'b01:   rd_ext = sign_q ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                  : {16'h0000, rd_shift[15:0]};
         default: rd_ext = rd_shift;
      endcase
   end

   // Output decode; everything is forced low while reset is asserted.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      ram_we    = 1'b0;
      ram_be    = 4'b0000;
      ram_wdata = '0;
      ram_addr  = reset_n ? ram_addr_q : '0;
      if (accept) req_ready[winner] = 1'b1;
      if (reset_n && state_q == ISSUE) begin
         ram_addr  = {addr_q[XLEN-1:2], 2'b00};
         ram_we    = we_q;
         ram_wdata = wdata_q << {addr_q[1:0], 3'b000};
         case (width_q)
            2'b00:   ram_be = 4'b0001 << addr_q[1:0];
            2'b01:   ram_be = 4'b0011 << addr_q[1:0];
            default: ram_be = 4'b1111;
         endcase
      end
      if (reset_n && state_q == RESP) begin
         rsp_valid[owner_q] = 1'b1;
         rsp_err            = err_q;
         rsp_rdata          = (err_q || we_q) ? '0 : rd_ext;
      end
   end

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// Testbench for rv32i_dmem_arbiter: directed accesses, arbitration order,
// mid-access reset, then randomized accesses against a byte-array memory model.
module tb_rv32i_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_we;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [3:0]  req_width;
   logic [1:0]  req_sign;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] ram_addr;
   logic        ram_we;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   logic        ram_clr;
   logic [31:0] ram_mem [0:63];
   logic [7:0]  ref_mem [0:255];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rv32i_dmem_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_width (req_width),
      .req_sign  (req_sign),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_be    (ram_be),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // Synchronous RAM with one-cycle read latency.
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 64; i++) ram_mem[i] <= 32'h0;
      end else if (ram_we) begin
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) ram_mem[ram_addr[7:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
      ram_rdata <= ram_mem[ram_addr[7:2]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int r, input bit v, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] width, input bit sign);
      req_valid[r]         = v;
      req_we[r]            = we;
      req_addr[r*32 +: 32] = addr;
      req_wdata[r*32 +: 32] = wdata;
      req_width[r*2 +: 2]  = width;
      req_sign[r]          = sign;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ready"}, {30'h0, req_ready}, 32'h0);
      check({tag, "_rsp_valid"}, {30'h0, rsp_valid}, 32'h0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
      check({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
      check({tag, "_ram_we"}, {31'h0, ram_we}, 32'h0);
      check({tag, "_ram_be"}, {28'h0, ram_be}, 32'h0);
      check({tag, "_ram_wdata"}, ram_wdata, 32'h0);
   endtask

   // One complete access by requester r; call and return at a falling edge.
   task automatic do_access(input int r, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] width, input bit sign);
      int          size;
      int          lane;
      bit          bad;
      bit          seen;
      logic [3:0]  exp_be;
      logic [31:0] exp_rd;
      size = 1 << width;
      lane = int'(addr[1:0]);
      bad  = (width == 2'b11) || ((int'(addr) % size) != 0);
      set_req(r, 1'b1, we, addr, wdata, width, sign);
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (req_ready[r]) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!seen) begin
         failures++;
         $error("FAIL accept_timeout observed=no_ready expected=ready_r%0d", r);
         req_valid[r] = 1'b0;
         return;
      end
      check("ready_onehot", {30'h0, req_ready}, 32'(1 << r));
      @(posedge clk);
      @(negedge clk);
      req_valid[r] = 1'b0;
      #1;
      if (bad) begin
         check("err_rsp_valid", {30'h0, rsp_valid}, 32'(1 << r));
         check("err_rsp_err", {31'h0, rsp_err}, 32'h1);
         check("err_rsp_rdata", rsp_rdata, 32'h0);
         check("err_ram_we", {31'h0, ram_we}, 32'h0);
         @(negedge clk);
         return;
      end
      exp_be = 4'b0000;
      for (int k = 0; k < size; k++) exp_be[lane+k] = 1'b1;
      check("issue_ram_we", {31'h0, ram_we}, {31'h0, we});
      check("issue_ram_be", {28'h0, ram_be}, {28'h0, exp_be});
      check("issue_ram_addr", ram_addr, {addr[31:2], 2'b00});
      check("issue_ram_wdata", ram_wdata, wdata << (8 * lane));
      check("issue_no_rsp", {30'h0, rsp_valid}, 32'h0);
      exp_rd = 32'h0;
      if (we) begin
         for (int k = 0; k < size; k++) ref_mem[(int'(addr) + k) & 255] = wdata[k*8 +: 8];
      end else begin
         for (int k = 0; k < size; k++)
            exp_rd = exp_rd | (32'(ref_mem[(int'(addr) + k) & 255]) << (8 * k));
         if (sign && size == 1 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFF_FF00;
         if (sign && size == 2 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
      end
      @(negedge clk);
      #1;
      check("rsp_valid", {30'h0, rsp_valid}, 32'(1 << r));
      check("rsp_err", {31'h0, rsp_err}, 32'h0);
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_ram_we", {31'h0, ram_we}, 32'h0);
      @(negedge clk);
   endtask

   initial begin
      int          acc_cnt;
      int          last_c;
      int          lastg;
      int          g;
      bit          seen;
      int          exp_order [4];
      logic [1:0]  exp_rv;
      int          r;
      bit          we;
      bit          sgn;
      logic [1:0]  w;
      logic [31:0] a;
      logic [31:0] d;

      reset_n   = 1'b0;
      ram_clr   = 1'b1;
      req_valid = 2'b00;
      req_we    = 2'b00;
      req_addr  = 64'h0;
      req_wdata = 64'h0;
      req_width = 4'h0;
      req_sign  = 2'b00;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

      @(negedge clk);
      @(negedge clk);
      #1;
      check_quiet("in_reset");
      check("in_reset_ram_addr", ram_addr, 32'h0);
      @(negedge clk);
      ram_clr = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      check_quiet("after_reset");
      @(negedge clk);

      do_access(0, 1'b1, 32'h50, 32'h80, 2'b00, 1'b0);
      do_access(0, 1'b0, 32'h50, 32'h0, 2'b00, 1'b0);
      do_access(0, 1'b0, 32'h50, 32'h0, 2'b00, 1'b1);
      do_access(0, 1'b1, 32'h62, 32'hFFFB, 2'b01, 1'b0);
      do_access(0, 1'b0, 32'h62, 32'h0, 2'b01, 1'b1);
      do_access(0, 1'b0, 32'h62, 32'h0, 2'b01, 1'b0);
      do_access(1, 1'b1, 32'h56, 32'h12345678, 2'b10, 1'b0);
      do_access(1, 1'b0, 32'h54, 32'h0, 2'b10, 1'b0);
      do_access(1, 1'b0, 32'h51, 32'h0, 2'b01, 1'b0);
      do_access(0, 1'b0, 32'h40, 32'h0, 2'b11, 1'b0);

      // Reset while a store sits in its RAM-issue cycle.
      set_req(0, 1'b1, 1'b1, 32'h70, 32'hAA, 2'b00, 1'b0);
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (req_ready[0]) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("rst_store_accepted", {31'h0, seen}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      reset_n   = 1'b0;
      #1;
      check("rst_issue_ram_we", {31'h0, ram_we}, 32'h0);
      check("rst_issue_rsp", {30'h0, rsp_valid}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_quiet("rst_after");
      @(negedge clk);

      // Both requesters hold loads; observe accept order and spacing.
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0};
`else
      exp_order = '{0, 1, 0, 1};
`endif
      set_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0);
      set_req(1, 1'b1, 1'b0, 32'h44, 32'h0, 2'b10, 1'b0);
      acc_cnt = 0;
      last_c  = -100;
      lastg   = 0;
      for (int c = 0; c < 40 && acc_cnt < 4; c++) begin
         #1;
         exp_rv = (c == last_c + 2) ? 2'(1 << lastg) : 2'b00;
         check("arb_rsp_valid", {30'h0, rsp_valid}, {30'h0, exp_rv});
         if (req_ready != 2'b00) begin
            g = int'(req_ready[1]);
            check("arb_order", 32'(g), 32'(exp_order[acc_cnt]));
            if (acc_cnt > 0) check("arb_spacing", 32'(c - last_c), 32'd3);
            last_c = c;
            lastg  = g;
            acc_cnt++;
         end
         @(negedge clk);
      end
      check("arb_count", 32'(acc_cnt), 32'd4);
      req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);

      do_access(0, 1'b0, 32'h70, 32'h0, 2'b00, 1'b0);

      // Randomized single-requester accesses.
      for (int n = 0; n < 40; n++) begin
         r   = int'($urandom_range(0, 1));
         we  = 1'($urandom_range(0, 1));
         sgn = 1'($urandom_range(0, 1));
         w   = 2'($urandom_range(0, 3));
         a   = 32'h40 + 32'($urandom_range(0, 63));
         d   = $urandom;
         if (w != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'h1 << w) - 32'h1);
         do_access(r, we, a, d, w, sgn);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
